agu_dtlb: RTL

//  Data-side Sv32 TLB answering AGU translation requests (virt_addr/isWrite -> translated_addr, ans_vld, excp).

---
 rtl/calvera_mmu_pkg.sv | 35 +++
 rtl/dtlb_cam.sv | 47 ++++
 rtl/agu_dtlb.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/calvera_mmu_pkg.sv
// rtl/calvera_mmu_pkg.sv - shared MMU types: PTE permission bits, exception codes, DTLB state
package calvera_mmu_pkg;

  typedef struct packed {
    logic d;
    logic a;
    logic g;
    logic u;
    logic x;
    logic w;
    logic r;
    logic v;
  } pte_perm_t;

  localparam logic [3:0] EXC_LD_ACC = 4'd5;
  localparam logic [3:0] EXC_ST_ACC = 4'd7;
  localparam logic [3:0] EXC_LD_PF  = 4'd13;
  localparam logic [3:0] EXC_ST_PF  = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } dtlb_state_t;

  typedef struct packed {
    logic      vld;
    logic      super_pg;
    logic [19:0] vpn;
    logic [21:0] ppn;
    pte_perm_t perm;
  } tlb_entry_t;

endpackage

// File: rtl/dtlb_cam.sv
// rtl/dtlb_cam.sv - fully-associative DTLB entry store with parallel match and refill/invalidate port
module dtlb_cam
  import calvera_mmu_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [19:0]        lookup_vpn_i,
  output logic [ENTRIES-1:0] hit_onehot_o,
  output tlb_entry_t         hit_entry_o,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  tlb_entry_t         wr_entry_i,
  input  logic               inval_all_i
);

  tlb_entry_t entries_q [ENTRIES];

  // Invalidate-all beats a same-cycle refill so an sfence never leaves a fresh entry behind.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
    end else if (inval_all_i) begin
      for (int i = 0; i < ENTRIES; i++) entries_q[i].vld <= 1'b0;
    end else if (wr_en_i) begin
      entries_q[wr_idx_i] <= wr_entry_i;
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      hit_onehot_o[i] = entries_q[i].vld &&
                        (entries_q[i].super_pg ? (entries_q[i].vpn[19:10] == lookup_vpn_i[19:10])
                                               : (entries_q[i].vpn == lookup_vpn_i));
    end
  end

  always_comb begin
    hit_entry_o = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (hit_onehot_o[i]) hit_entry_o = entries_q[i];
    end
  end

endmodule

// File: rtl/agu_dtlb.sv
// rtl/agu_dtlb.sv - Sv32 data TLB with miss FSM; DTLB_SUPERPAGE_EN enables native 4 MiB entries
module agu_dtlb
  import calvera_mmu_pkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic        cpu_clock_i,
  input  logic        cpu_reset_i,
  input  logic        flush_i,
  input  logic        sfence_i,
  input  logic        satp_mode_i,
  input  logic [1:0]  priv_i,
  input  logic        sum_i,
  input  logic [31:0] virt_addr_i,
  input  logic        virt_addr_vld_i,
  input  logic        isWrite_i,
  output logic [31:0] translated_addr_o,
  output logic [3:0]  excp_code_o,
  output logic        excp_code_vld_o,
  output logic        ans_vld_o,
  output logic        ptw_req_o,
  output logic [19:0] ptw_vpn_o,
  input  logic        ptw_gnt_i,
  input  logic        ptw_resp_vld_i,
  input  logic [21:0] ptw_ppn_i,
  input  logic [7:0]  ptw_perm_i,
  input  logic        ptw_super_i,
  input  logic        ptw_fault_i
);

  localparam int IDX_W = $clog2(ENTRIES);

  dtlb_state_t        state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [19:0]        vpn_q, vpn_d;
  logic               wr_q, wr_d;
  logic               flt_vld_q, flt_vld_d;
  logic [19:0]        flt_vpn_q, flt_vpn_d;
  logic               flt_wr_q, flt_wr_d;

  logic [ENTRIES-1:0] hit_onehot;
  tlb_entry_t         hit_entry;
  tlb_entry_t         wr_entry;
  logic               misalign;
  logic               bypass, hit, flt_match, miss, perm_fail, acc_fail;
  logic               resp_take, refill_we, fault_set;
  logic [31:0]        pa_hit;
  logic               unused_cam;

  dtlb_cam #(.ENTRIES(ENTRIES)) u_cam (
    .clk_i        (cpu_clock_i),
    .rst_i        (cpu_reset_i),
    .lookup_vpn_i (virt_addr_i[31:12]),
    .hit_onehot_o (hit_onehot),
    .hit_entry_o  (hit_entry),
    .wr_en_i      (refill_we),
    .wr_idx_i     (rr_q),
    .wr_entry_i   (wr_entry),
    .inval_all_i  (sfence_i)
  );

  assign unused_cam = ^{hit_entry.vld, hit_entry.vpn, hit_entry.perm.g, hit_entry.perm.x, hit_entry.perm.v};

  always_comb begin
    wr_entry      = '0;
    wr_entry.vld  = 1'b1;
    wr_entry.vpn  = vpn_q;
    wr_entry.perm = ptw_perm_i;
`ifdef DTLB_SUPERPAGE_EN
    wr_entry.super_pg = ptw_super_i;
    wr_entry.ppn      = ptw_ppn_i;
    misalign          = 1'b0;
`else
    // Without megapage entries a 4 MiB leaf is splintered into the 4 KiB page being accessed.
    wr_entry.super_pg = 1'b0;
    wr_entry.ppn      = ptw_super_i ? {ptw_ppn_i[21:10], vpn_q[9:0]} : ptw_ppn_i;
    misalign          = ptw_super_i && (ptw_ppn_i[9:0] != 10'd0);
`endif
  end

  assign bypass    = !satp_mode_i || (priv_i == 2'd3);
  assign hit       = |hit_onehot;
  assign flt_match = flt_vld_q && (flt_vpn_q == virt_addr_i[31:12]) && (flt_wr_q == isWrite_i);
  assign miss      = virt_addr_vld_i && !bypass && !hit && !flt_match;
  assign perm_fail = (isWrite_i ? !(hit_entry.perm.w && hit_entry.perm.a && hit_entry.perm.d)
                                : !(hit_entry.perm.r && hit_entry.perm.a)) ||
                     ((priv_i == 2'd1) && hit_entry.perm.u && !sum_i) ||
                     ((priv_i == 2'd0) && !hit_entry.perm.u);
  assign acc_fail  = |hit_entry.ppn[21:20];
  assign pa_hit    = hit_entry.super_pg ? {hit_entry.ppn[19:10], virt_addr_i[21:0]}
                                        : {hit_entry.ppn[19:0], virt_addr_i[11:0]};

  always_comb begin
    translated_addr_o = virt_addr_i;
    ans_vld_o         = 1'b0;
    excp_code_vld_o   = 1'b0;
    excp_code_o       = 4'd0;
    if (bypass) begin
      ans_vld_o = virt_addr_vld_i;
    end else if (flt_match) begin
      ans_vld_o       = virt_addr_vld_i;
      excp_code_vld_o = virt_addr_vld_i;
      excp_code_o     = isWrite_i ? EXC_ST_PF : EXC_LD_PF;
    end else if (hit) begin
      ans_vld_o         = virt_addr_vld_i;
      translated_addr_o = pa_hit;
      if (perm_fail) begin
        excp_code_vld_o = virt_addr_vld_i;
        excp_code_o     = isWrite_i ? EXC_ST_PF : EXC_LD_PF;
      end else if (acc_fail) begin
        excp_code_vld_o = virt_addr_vld_i;
        excp_code_o     = isWrite_i ? EXC_ST_ACC : EXC_LD_ACC;
      end
    end
  end

  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      vpn_q     <= '0;
      wr_q      <= 1'b0;
      flt_vld_q <= 1'b0;
      flt_vpn_q <= '0;
      flt_wr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      vpn_q     <= vpn_d;
      wr_q      <= wr_d;
      flt_vld_q <= flt_vld_d;
      flt_vpn_q <= flt_vpn_d;
      flt_wr_q  <= flt_wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (miss && !flush_i) state_d = REQ;
      REQ:   if (ptw_gnt_i) state_d = flush_i ? DRAIN : WAIT;
             else if (flush_i) state_d = IDLE;
      WAIT:  if (ptw_resp_vld_i) state_d = IDLE;
             else if (flush_i) state_d = DRAIN;
      DRAIN: if (ptw_resp_vld_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptw_req_o = (state_q == REQ);
    ptw_vpn_o = vpn_q;
    resp_take = (state_q == WAIT) && ptw_resp_vld_i && !flush_i;
    fault_set = resp_take && (ptw_fault_i || misalign);
    refill_we = resp_take && !ptw_fault_i && !misalign && !sfence_i;
  end

  always_comb begin
    rr_d      = rr_q;
    vpn_d     = vpn_q;
    wr_d      = wr_q;
    flt_vld_d = flt_vld_q;
    flt_vpn_d = flt_vpn_q;
    flt_wr_d  = flt_wr_q;
    if (refill_we) rr_d = (rr_q == IDX_W'(ENTRIES - 1)) ? '0 : rr_q + 1'b1;
    if ((state_q == IDLE) && miss && !flush_i) begin
      vpn_d = virt_addr_i[31:12];
      wr_d  = isWrite_i;
    end
    if (sfence_i || flush_i) begin
      flt_vld_d = 1'b0;
    end else if (fault_set) begin
      flt_vld_d = 1'b1;
      flt_vpn_d = vpn_q;
      flt_wr_d  = wr_q;
    end else if (virt_addr_vld_i && !bypass && flt_match) begin
      flt_vld_d = 1'b0;
    end
  end

endmodule
